reg_rename_file: RTL
====================

# reg_rename_file

Architectural register file with per-register rename tags, sitting between dispatch and the reorder buffer. Dispatch reads source operands and their producer ROB tags from it and renames destinations to the ROB tag being allocated. The ROB commit port writes retired values back and releases tags. A flush zeroes every tag so all operands read from architectural state.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired zero.
- TAG_W, 5, ROB tag width; tag 0 means "no pending producer", tags 1..16 are valid.
- VAL_W, 32, register value width.

Ports:
- clk_in  in  1  single clock; all state updates on the rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; when low, all state holds and commit/rename/clear are ignored.
- rs1_idx  in  5  dispatch source 1 register index.
- rs2_idx  in  5  dispatch source 2 register index.
- rs1_val  out  VAL_W  source 1 architectural value, bypassed.
- rs2_val  out  VAL_W  source 2 architectural value, bypassed.
- rs1_rely  out  TAG_W  source 1 producer tag; 0 means the value is ready.
- rs2_rely  out  TAG_W  source 2 producer tag.
- rename_en  in  1  dispatch is allocating an instruction with a destination.
- rename_rd  in  5  destination register of the allocating instruction.
- rename_tag  in  TAG_W  ROB tag allocated, equal to ROB_next_tag.
- write_rdy  in  1  ROB commit writes a register.
- to_rd  in  5  committed destination register.
- write_val  in  VAL_W  committed value.
- head_tag  in  TAG_W  ROB tag of the committing entry.
- clear  in  1  misprediction flush from the ROB.
- commit_cnt  out  32  count of accepted commit writes to non-zero rd, for debug.

## Operation
- State: val[0..31] is VAL_W wide, tag[0..31] is TAG_W wide, plus commit_cnt.
- Reset, asynchronous: all val = 0, all tag = 0, commit_cnt = 0. All outputs derived from state therefore read 0 immediately.
- Reads are combinational. For rsN:
  - If idx == 0: val 0, rely 0.
  - Else if write_rdy && to_rd == idx && tag[idx] == head_tag: val = write_val, rely = 0. This is the commit bypass.
  - Else if tag[idx] == 0: val = val[idx], rely = 0.
  - Else: val = val[idx], rely = tag[idx].
- Commit, when rdy_in and write_rdy and to_rd != 0:
  - val[to_rd] <= write_val.
  - commit_cnt increments.
  - If tag[to_rd] == head_tag, tag[to_rd] <= 0. Otherwise the tag is kept, because a younger producer owns the register.
- Rename, when rdy_in and rename_en and rename_rd != 0 and !clear: tag[rename_rd] <= rename_tag.
- Clear, when rdy_in and clear: all tags <= 0; any rename in that cycle is dropped. A commit write in the same cycle is still applied to val, because the ROB asserts clear together with the write of the jumping instruction.
- Priority on tag[r] in one cycle: clear > rename > commit release.
- x0 is never written, never tagged, and is not counted.
- rename_tag == 0 is illegal. Behaviour is undefined and the bench treats it as a protocol error.

## Timing
- Read latency 0 cycles, combinational from idx and the commit inputs.
- Commit, rename and clear take effect at the next rising edge after being sampled; the updated state is visible the same cycle after that edge.
- Same-cycle rename and commit release on the same rd: the new tag wins, and the value is still written.
- Same-cycle rename of rd with a read of rd: the read returns the pre-rename tag. Dispatch reads sources before its own destination rename.
- rdy_in low: no state change, reads still valid.
- rst_in asserted mid-cycle: state clears immediately regardless of clk_in or rdy_in. After deassertion, operation resumes on the next edge.
- commit_cnt wraps modulo 2^32.

## Test plan
- Reset, then read x5/x0: rs1_val = 0, rs1_rely = 0. Commit x0 with value 0xFFFFFFFF: x0 still reads 0, commit_cnt = 0.
- Rename x3 -> tag 4; next cycle read x3: rely = 4, val = 0. Commit to_rd = 3, head_tag = 4, val 0x1234: during that cycle the bypass gives val = 0x1234, rely = 0. After the edge, tag[3] = 0, val[3] = 0x1234, commit_cnt = 1.
- Rename x7 -> tag 2, then x7 -> tag 5. Commit head_tag = 2 to x7 with val 9: val[7] = 9, rely still 5, no bypass.
- Same cycle: rename x8 -> tag 6 and commit x8 with head_tag = 3 (tag[8] = 3): after the edge tag[8] = 6 and the value is written.
- Tags on x1, x2, x9. Then clear + write_rdy to x1 with val 0xAA + rename x10 -> tag 7: all tags = 0, val[1] = 0xAA, tag[10] = 0.
- Rename x4 -> tag 3 with rdy_in = 0: tag[4] stays 0. Assert rst_in asynchronously between edges: outputs read 0 before the next edge.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags.
// Dispatch reads operands plus producer ROB tags; the ROB commit port
// retires values and releases tags; a flush zeroes every tag.
module reg_rename_file #(
  parameter int REG_NUM = 32,
  parameter int TAG_W   = 5,
  parameter int VAL_W   = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic [VAL_W-1:0] rs1_val,
  output logic [VAL_W-1:0] rs2_val,
  output logic [TAG_W-1:0] rs1_rely,
  output logic [TAG_W-1:0] rs2_rely,
  input  logic             rename_en,
  input  logic [4:0]       rename_rd,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic             write_rdy,
  input  logic [4:0]       to_rd,
  input  logic [VAL_W-1:0] write_val,
  input  logic [TAG_W-1:0] head_tag,
  input  logic             clear,
  output logic [31:0]      commit_cnt
);

  logic [VAL_W-1:0] val_q [REG_NUM];
  logic [TAG_W-1:0] tag_q [REG_NUM];

  logic commit_hit;
  logic rename_hit;

  assign commit_hit = write_rdy && (to_rd != 5'd0);
  assign rename_hit = rename_en && (rename_rd != 5'd0) && !clear;

  // Source 1 read: x0 is zero, commit bypass when the committing entry
  // still owns the register, otherwise architectural value plus tag.
  always_comb begin
    rs1_val  = '0;
    rs1_rely = '0;
    if (rs1_idx != 5'd0) begin
      if (write_rdy && (to_rd == rs1_idx) && (tag_q[rs1_idx] == head_tag)) begin
        rs1_val = write_val;
      end else begin
        rs1_val  = val_q[rs1_idx];
        rs1_rely = tag_q[rs1_idx];
      end
    end
  end

  // Source 2 read, same rules as source 1.
  always_comb begin
    rs2_val  = '0;
    rs2_rely = '0;
    if (rs2_idx != 5'd0) begin
      if (write_rdy && (to_rd == rs2_idx) && (tag_q[rs2_idx] == head_tag)) begin
        rs2_val = write_val;
      end else begin
        rs2_val  = val_q[rs2_idx];
        rs2_rely = tag_q[rs2_idx];
      end
    end
  end

  // State update. Tag assignments are ordered so later ones win:
  // commit release, then rename, then clear (clear > rename > release).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      commit_cnt <= '0;
    end else if (rdy_in) begin
      if (commit_hit) begin
        val_q[to_rd] <= write_val;
        commit_cnt   <= commit_cnt + 32'd1;
        if (tag_q[to_rd] == head_tag) begin
          tag_q[to_rd] <= '0;
        end
      end
      if (rename_hit) begin
        tag_q[rename_rd] <= rename_tag;
      end
      if (clear) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          tag_q[i] <= '0;
        end
      end
    end
  end

endmodule
